// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit FIFO: drain FSM encoding and default sizing.
package uart_pkg;

  localparam int UART_TX_ADDR_BITS    = 6;
  localparam int UART_TX_BUSY_TIMEOUT = 15;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_LAUNCH  = 2'd1;
  localparam logic [1:0] ST_WAIT_HI = 2'd2;
  localparam logic [1:0] ST_WAIT_LO = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    LAUNCH  = ST_LAUNCH,
    WAIT_HI = ST_WAIT_HI,
    WAIT_LO = ST_WAIT_LO
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_mem.sv
// Byte storage for the UART transmit FIFO: synchronous write, asynchronous read.
module uart_tx_fifo_mem #(
  parameter int ADDR_BITS = 6
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [7:0]           wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [7:0]           rdata
);

  logic [7:0] mem [0:(1 << ADDR_BITS)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO between MMIO writes and the UART core, with a one-byte-at-a-time drain FSM.
// Optional statistics outputs (high_water, drop_count) when UART_TX_FIFO_STATS_EN is defined.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int ADDR_BITS    = UART_TX_ADDR_BITS,
  parameter int BUSY_TIMEOUT = UART_TX_BUSY_TIMEOUT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [7:0]         wr_data,
  input  logic               flush,
  output logic               full,
  output logic               empty,
  output logic [ADDR_BITS:0] level,
  output logic               overflow,
  output logic [7:0]         uart_tx_data,
  output logic               uart_tx_valid,
  input  logic               uart_tx_busy,
`ifdef UART_TX_FIFO_STATS_EN
  output logic [ADDR_BITS:0] high_water,
  output logic [15:0]        drop_count,
`endif
  output logic               idle
);

  localparam logic [ADDR_BITS:0] DEPTH_L = {1'b1, {ADDR_BITS{1'b0}}};
  localparam int                 TW      = $clog2(BUSY_TIMEOUT + 2);
  localparam logic [TW-1:0]      TIMEOUT_L = TW'(BUSY_TIMEOUT);

  logic [ADDR_BITS-1:0] wr_ptr;
  logic [ADDR_BITS-1:0] rd_ptr;
  logic [ADDR_BITS:0]   level_nxt;
  logic [7:0]           rd_data;
  logic [TW-1:0]        timer;
  tx_state_e            state;
  logic                 push;
  logic                 pop;
  logic                 drop;

  assign full  = (level == DEPTH_L);
  assign empty = (level == '0);
  assign idle  = empty && (state == IDLE);

  // full is judged on the pre-edge level, so a pop in the same cycle never admits a push.
  assign push = wr_en && !full && !flush;
  assign drop = wr_en && full && !flush;
  // A flush also blocks a pop so no flushed byte can slip out on the flush edge.
  assign pop  = (state == IDLE) && !empty && !uart_tx_busy && !flush;

  assign uart_tx_valid = (state == LAUNCH);

  uart_tx_fifo_mem #(
    .ADDR_BITS (ADDR_BITS)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  always_comb begin
    level_nxt = level;
    if (flush) begin
      level_nxt = '0;
    end else begin
      case ({push, pop})
        2'b10:   level_nxt = level + 1'b1;
        2'b01:   level_nxt = level - 1'b1;
        default: level_nxt = level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      level <= level_nxt;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (flush) begin
        rd_ptr   <= wr_ptr;
        overflow <= 1'b0;
      end else begin
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        if (drop) begin
          overflow <= 1'b1;
        end
      end
    end
  end

  // Flush deliberately leaves the FSM alone so an in-flight byte runs to completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      timer        <= '0;
      uart_tx_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            uart_tx_data <= rd_data;
            state        <= LAUNCH;
          end
        end
        LAUNCH: begin
          timer <= '0;
          state <= WAIT_HI;
        end
        WAIT_HI: begin
          if (uart_tx_busy) begin
            state <= WAIT_LO;
          end else if (timer == TIMEOUT_L) begin
            state <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        WAIT_LO: begin
          if (!uart_tx_busy) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UART_TX_FIFO_STATS_EN
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      high_water <= '0;
      drop_count <= '0;
    end else begin
      if (level_nxt > high_water) begin
        high_water <= level_nxt;
      end
      if (drop && (drop_count != '1)) begin
        drop_count <= drop_count + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: expected bytes are queued at push time, a monitor checks each launch.
module tb_uart_tx_fifo;

  localparam int AB = 6;
  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        flush;
  logic        full;
  logic        empty;
  logic [AB:0] level;
  logic        overflow;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_busy;
  logic        idle;
  logic        model_busy = 1'b0;
  logic        hold_busy  = 1'b0;
`ifdef UART_TX_FIFO_STATS_EN
  logic [AB:0] high_water;
  logic [15:0] drop_count;
`endif

  assign uart_tx_busy = model_busy | hold_busy;

  uart_tx_fifo #(
    .ADDR_BITS    (AB),
    .BUSY_TIMEOUT (TO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .flush         (flush),
    .full          (full),
    .empty         (empty),
    .level         (level),
    .overflow      (overflow),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_valid (uart_tx_valid),
    .uart_tx_busy  (uart_tx_busy),
`ifdef UART_TX_FIFO_STATS_EN
    .high_water    (high_water),
    .drop_count    (drop_count),
`endif
    .idle          (idle)
  );

  always #10 clk = ~clk;

  int         checks   = 0;
  int         errors   = 0;
  int         cyc      = 0;
  int         launches = 0;
  int         launch_cyc[$];
  logic [7:0] exp_q[$];
  logic [7:0] mon_e;
  bit         model_en = 1'b1;
  int         busy_len = 500;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every launch pulse must match the oldest expected byte and never coincide with busy.
  initial begin
    forever begin
      @(negedge clk);
      if (uart_tx_valid === 1'b1) begin
        launches++;
        launch_cyc.push_back(cyc);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL launch_unexpected actual=%0h expected=none", uart_tx_data);
        end else begin
          mon_e = exp_q.pop_front();
          if (uart_tx_data !== mon_e) begin
            errors++;
            $display("FAIL launch_data actual=%0h expected=%0h", uart_tx_data, mon_e);
          end
        end
        checks++;
        if (uart_tx_busy !== 1'b0) begin
          errors++;
          $display("FAIL launch_while_busy actual=%0b expected=0", uart_tx_busy);
        end
      end
    end
  end

  // UART core model: busy rises 3 cycles after a launch and stays up for busy_len cycles.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (uart_tx_valid && model_en) begin
        repeat (3) begin
          @(posedge clk);
          #1;
        end
        model_busy = 1'b1;
        repeat (busy_len) begin
          @(posedge clk);
          #1;
        end
        model_busy = 1'b0;
      end
    end
  end

  initial begin
    #4_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int base;
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    flush   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid",    int'(uart_tx_valid), 0);
    chk("rst_data",     int'(uart_tx_data), 0);
    chk("rst_full",     int'(full), 0);
    chk("rst_empty",    int'(empty), 1);
    chk("rst_idle",     int'(idle), 1);
    chk("rst_level",    int'(level), 0);
    chk("rst_overflow", int'(overflow), 0);
    reset = 1'b0;
    @(negedge clk);

    // Single byte, latency and pulse width
    model_en = 1'b1;
    busy_len = 500;
    wr_en = 1'b1; wr_data = 8'h41; exp_q.push_back(8'h41);
    @(negedge clk);
    wr_en = 1'b0;
    chk("single_pre_valid", int'(uart_tx_valid), 0);
    chk("single_level1", int'(level), 1);
    @(negedge clk);
    chk("single_launch_valid", int'(uart_tx_valid), 1);
    chk("single_launch_data", int'(uart_tx_data), 'h41);
    @(negedge clk);
    chk("single_pulse_width", int'(uart_tx_valid), 0);
    n = 0;
    while (!uart_tx_busy && n < 20) begin @(negedge clk); n++; end
    chk("single_busy_rise", int'(uart_tx_busy), 1);
    n = 0;
    while (uart_tx_busy && n < 600) begin @(negedge clk); n++; end
    chk("single_busy_fall", int'(uart_tx_busy), 0);
    chk("single_idle_lag", int'(idle), 0);
    @(negedge clk);
    chk("single_idle_after", int'(idle), 1);

    // Burst fill with UART held busy, then overflow, then drain in order
    busy_len  = 8;
    hold_busy = 1'b1;
    for (int i = 0; i < 64; i++) begin
      wr_en = 1'b1; wr_data = 8'(i); exp_q.push_back(8'(i));
      @(negedge clk);
    end
    wr_en = 1'b0;
    chk("burst_full",     int'(full), 1);
    chk("burst_level",    int'(level), 64);
    chk("burst_empty",    int'(empty), 0);
    chk("burst_overflow0", int'(overflow), 0);
    wr_en = 1'b1; wr_data = 8'hEE;
    @(negedge clk);
    wr_en = 1'b0;
    chk("ovf_flag",  int'(overflow), 1);
    chk("ovf_level", int'(level), 64);
    chk("ovf_full",  int'(full), 1);
`ifdef UART_TX_FIFO_STATS_EN
    chk("ovf_drop_count", int'(drop_count), 1);
    chk("ovf_high_water", int'(high_water), 64);
`endif
    hold_busy = 1'b0;
    n = 0;
    while (!(idle && !uart_tx_busy && exp_q.size() == 0) && n < 3000) begin @(negedge clk); n++; end
    chk("burst_drained", exp_q.size(), 0);
    chk("burst_idle", int'(idle), 1);
    chk("burst_launches", launches, 65);
    chk("ovf_sticky", int'(overflow), 1);

    // Flush on an empty FIFO clears overflow
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_ovf_clear", int'(overflow), 0);
    chk("flush_empty", int'(empty), 1);
`ifdef UART_TX_FIFO_STATS_EN
    chk("flush_drop_count", int'(drop_count), 0);
    chk("flush_high_water", int'(high_water), 0);
`endif

    // Busy never rises: each byte times out and the next one launches
    model_en = 1'b0;
    base = launches;
    wr_en = 1'b1; wr_data = 8'h55; exp_q.push_back(8'h55);
    @(negedge clk);
    wr_data = 8'h56; exp_q.push_back(8'h56);
    @(negedge clk);
    wr_en = 1'b0;
    n = 0;
    while (launches < base + 2 && n < 100) begin @(negedge clk); n++; end
    chk("timeout_launches", launches - base, 2);
    if (launch_cyc.size() >= 2)
      chk("timeout_gap", launch_cyc[$] - launch_cyc[$-1], TO + 3);
    n = 0;
    while (!idle && n < 100) begin @(negedge clk); n++; end
    chk("timeout_idle", int'(idle), 1);

    // Flush while the first of ten bytes is in WAIT_LO
    model_en = 1'b1;
    busy_len = 30;
    base = launches;
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1; wr_data = 8'hA0 + 8'(i);
      if (i == 0) exp_q.push_back(8'hA0);
      @(negedge clk);
    end
    wr_en = 1'b0;
    n = 0;
    while (!uart_tx_busy && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fmid_level", int'(level), 0);
    chk("fmid_empty", int'(empty), 1);
    chk("fmid_overflow", int'(overflow), 0);
    chk("fmid_inflight", int'(idle), 0);
    repeat (60) @(negedge clk);
    chk("fmid_launches", launches - base, 1);
    chk("fmid_idle", int'(idle), 1);

    // Reset while in WAIT_HI
    model_en = 1'b0;
    base = launches;
    wr_en = 1'b1; wr_data = 8'h77; exp_q.push_back(8'h77);
    @(negedge clk);
    wr_data = 8'h78;
    @(negedge clk);
    wr_en = 1'b0;
    chk("rmid_launch", int'(uart_tx_valid), 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rmid_valid", int'(uart_tx_valid), 0);
    chk("rmid_empty", int'(empty), 1);
    chk("rmid_idle",  int'(idle), 1);
    chk("rmid_level", int'(level), 0);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    chk("rmid_no_relaunch", launches - base, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Transmit-side buffer between the MMIO peripheral block (producer) and the UART core TX input (consumer).
- CPU byte writes are queued in a circular FIFO. A drain FSM then presents one byte at a time to the UART core: a one-cycle tx_ena pulse, followed by waiting out tx_busy.
- Removes CPU stalls on uart_tx_busy polling at 1 Mbaud / 50 MHz.

Parameters:
- ADDR_BITS, 6: FIFO depth = 2**ADDR_BITS entries (64 bytes).
- BUSY_TIMEOUT, 15: maximum cycles to wait for uart_tx_busy to rise after a launch before treating the byte as sent.

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  push request from MMIO (one byte per cycle).
- wr_data  in  8  byte to push.
- flush  in  1  synchronous clear of queued bytes; an in-flight byte still completes.
- full  out  1  FIFO holds 2**ADDR_BITS bytes.
- empty  out  1  FIFO holds 0 bytes.
- level  out  ADDR_BITS+1  current occupancy.
- overflow  out  1  sticky: a push was attempted while full; cleared by reset or flush.
- uart_tx_data  out  8  byte to UART core; stable while uart_tx_valid is high.
- uart_tx_valid  out  1  one-cycle launch pulse (drives UART tx_ena).
- uart_tx_busy  in  1  UART core transmitter busy.
- idle  out  1  FIFO empty and FSM in IDLE (safe-to-reboot indicator).

Behaviour:
- Reset (clk edge with reset=1):
  - rd/wr pointers = 0, level = 0.
  - FSM = IDLE.
  - uart_tx_valid = 0, uart_tx_data = 0x00, overflow = 0.
  - full = 0, empty = 1, idle = 1.
- Storage:
  - Pointers are ADDR_BITS wide and wrap modulo depth.
  - level is ADDR_BITS+1 bits. full = (level == depth), empty = (level == 0); both are registered-equivalent and reflect the state after the last edge.
- Push:
  - wr_en & !full: write mem[wr_ptr], wr_ptr+1, level+1.
  - wr_en & full: byte dropped, overflow set.
- Pop: happens only on the IDLE->LAUNCH transition. mem[rd_ptr] is latched into uart_tx_data, rd_ptr+1, level-1.
- Simultaneous push and pop in one cycle: level unchanged, both pointers advance. Push while full plus pop in the same cycle is still rejected, because full is evaluated before the pop.
- FSM:
  - IDLE: if !empty and !uart_tx_busy, pop and go to LAUNCH.
  - LAUNCH: uart_tx_valid = 1 for exactly this cycle; go to WAIT_HI with timer = 0.
  - WAIT_HI: if uart_tx_busy, go to WAIT_LO. Otherwise timer+1; if timer == BUSY_TIMEOUT, go to IDLE (byte considered consumed).
  - WAIT_LO: go to IDLE when uart_tx_busy == 0.
- Latency: byte pushed into an empty FIFO with the UART idle → uart_tx_valid high 2 cycles after the push edge (push edge, IDLE pop edge, LAUNCH).
- Back-to-back bytes: the next launch occurs no earlier than 2 cycles after uart_tx_busy falls.
- flush:
  - Sets rd_ptr = wr_ptr, level = 0, clears overflow.
  - A wr_en in the same cycle is ignored (flush wins).
  - The FSM is not reset: a byte already launched finishes its WAIT states.
- idle = empty & (state == IDLE).
- Reset mid-byte: the FSM returns to IDLE immediately and uart_tx_valid drops. The UART core finishes or aborts per its own reset.

Optional Feature:
- Macro: UART_TX_FIFO_STATS_EN.
- When defined, two extra outputs are added:
  - high_water (ADDR_BITS+1): maximum level seen since reset/flush.
  - drop_count (16): saturating count of rejected pushes.
  - Both clear on reset or flush. drop_count saturates at 0xFFFF.
- When undefined, these ports and their registers are absent. All other behaviour is identical.

Decomposition:
- Shared package uart_pkg holds:
  - FSM state encoding: IDLE=2'd0, LAUNCH=2'd1, WAIT_HI=2'd2, WAIT_LO=2'd3.
  - Default depth and timeout constants.
- One natural sub-module: uart_tx_fifo_mem, a 2**ADDR_BITS x 8 synchronous-write, async-read array that maps to iCE40 logic/BRAM. The pointers, level and FSM stay in the parent.

Test Plan:
- Single byte: push 0x41 with busy=0 → uart_tx_valid high for exactly 1 cycle, 2 cycles after the push, with uart_tx_data=0x41. Model busy high 3 cycles later for 500 cycles; idle=1 after busy falls plus 1 cycle.
- Burst and ordering: push 0x00..0x3F back-to-back (64 bytes) → full=1 and level=64 after the last push. The UART model receives 0x00..0x3F in order, with no launch while busy=1.
- Overflow: fill to 64, push 0xEE → byte dropped, overflow=1, level stays 64. With STATS_EN, drop_count=1.
- Timeout: model never asserts busy; push 0x55 → FSM returns to IDLE after BUSY_TIMEOUT+1 cycles in WAIT_HI, and the next byte launches.
- Flush mid-transfer: queue 10 bytes, flush while in WAIT_LO → level=0, empty=1, overflow=0. The current byte completes; no further uart_tx_valid pulses occur.
- Reset mid-byte: assert reset during WAIT_HI → next cycle uart_tx_valid=0, empty=1, idle=1, level=0.
